// File: rtl/ycbcr_sobel_edge.sv
// Sobel edge detector on the luma stream: two line buffers, 3x3 window, |Gx|+|Gy|, threshold.
// Define SOBEL_MAG_OUT_EN to output the saturated magnitude instead of a binary edge pixel.
module ycbcr_sobel_edge #(
  parameter int unsigned IMG_WIDTH = 640,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pre_frame_vsync,
  input  logic       pre_frame_hsync,
  input  logic       pre_frame_de,
  input  logic [7:0] img_y,
  input  logic [7:0] threshold,
  output logic       post_frame_vsync,
  output logic       post_frame_hsync,
  output logic       post_frame_de,
  output logic [7:0] post_img_data
);

  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_WIDTH - 1);

  logic [ADDR_W-1:0] col_q, col_d;
  logic              sat_q, sat_d;
  logic [10:0]       row_q, row_d;
  logic              vsync_q, de_q;
  logic [3:0]        vs_dly_q, hs_dly_q, de_dly_q;
  logic [7:0]        p11_q, p12_q, p13_q, p21_q, p22_q, p23_q, p31_q, p32_q, p33_q;
  logic              mask_d, mask_s1_q, mask_s2_q, mask_s3_q;
  logic signed [10:0] gx_d, gy_d, gx_q, gy_q;
  logic [10:0]       gx_pos, gx_neg, gy_pos, gy_neg, gx_abs, gy_abs;
  logic [10:0]       mag_d, mag_q;
  logic [7:0]        out_d, out_q;
  logic [7:0]        lb0_q [IMG_WIDTH];
  logic [7:0]        lb1_q [IMG_WIDTH];
  logic [7:0]        lb0_rd, lb1_rd;
  logic              lb_we;

  assign lb0_rd = lb0_q[col_q];
  assign lb1_rd = lb1_q[col_q];
  // Pixels beyond the last column are windowed but never overwrite the buffers.
  assign lb_we  = pre_frame_de && !sat_q;

  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb0_q[col_q] <= img_y;
      lb1_q[col_q] <= lb0_rd;
    end
  end

  always_comb begin
    col_d = col_q;
    sat_d = sat_q;
    row_d = row_q;
    if (pre_frame_de) begin
      if (col_q == COL_LAST) sat_d = 1'b1;
      else                   col_d = col_q + 1'b1;
    end else begin
      col_d = '0;
      sat_d = 1'b0;
    end
    if (pre_frame_vsync && !vsync_q)
      row_d = '0;
    else if (!pre_frame_de && de_q && (row_q != 11'd2047))
      row_d = row_q + 11'd1;
  end

  assign mask_d = (row_q < 11'd2) || (col_q < ADDR_W'(2));

  always_comb begin
    gx_pos = 11'(p13_q) + {2'b00, p23_q, 1'b0} + 11'(p33_q);
    gx_neg = 11'(p11_q) + {2'b00, p21_q, 1'b0} + 11'(p31_q);
    gy_pos = 11'(p31_q) + {2'b00, p32_q, 1'b0} + 11'(p33_q);
    gy_neg = 11'(p11_q) + {2'b00, p12_q, 1'b0} + 11'(p13_q);
    gx_d   = gx_pos - gx_neg;
    gy_d   = gy_pos - gy_neg;
    gx_abs = gx_q[10] ? 11'(-gx_q) : 11'(gx_q);
    gy_abs = gy_q[10] ? 11'(-gy_q) : 11'(gy_q);
    mag_d  = gx_abs + gy_abs;
  end

  always_comb begin
    out_d = '0;
    if (de_dly_q[2] && !mask_s3_q) begin
`ifdef SOBEL_MAG_OUT_EN
      out_d = (mag_q > 11'd255) ? 8'hFF : mag_q[7:0];
`else
      out_d = (mag_q > {3'b000, threshold}) ? 8'hFF : 8'h00;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q     <= '0;
      sat_q     <= 1'b0;
      row_q     <= '0;
      vsync_q   <= 1'b0;
      de_q      <= 1'b0;
      vs_dly_q  <= '0;
      hs_dly_q  <= '0;
      de_dly_q  <= '0;
      {p11_q, p12_q, p13_q} <= '0;
      {p21_q, p22_q, p23_q} <= '0;
      {p31_q, p32_q, p33_q} <= '0;
      mask_s1_q <= 1'b0;
      mask_s2_q <= 1'b0;
      mask_s3_q <= 1'b0;
      gx_q      <= '0;
      gy_q      <= '0;
      mag_q     <= '0;
      out_q     <= '0;
    end else begin
      col_q     <= col_d;
      sat_q     <= sat_d;
      row_q     <= row_d;
      vsync_q   <= pre_frame_vsync;
      de_q      <= pre_frame_de;
      vs_dly_q  <= {vs_dly_q[2:0], pre_frame_vsync};
      hs_dly_q  <= {hs_dly_q[2:0], pre_frame_hsync};
      de_dly_q  <= {de_dly_q[2:0], pre_frame_de};
      if (pre_frame_de) begin
        {p11_q, p12_q, p13_q} <= {p12_q, p13_q, lb1_rd};
        {p21_q, p22_q, p23_q} <= {p22_q, p23_q, lb0_rd};
        {p31_q, p32_q, p33_q} <= {p32_q, p33_q, img_y};
      end
      mask_s1_q <= mask_d;
      mask_s2_q <= mask_s1_q;
      mask_s3_q <= mask_s2_q;
      gx_q      <= gx_d;
      gy_q      <= gy_d;
      mag_q     <= mag_d;
      out_q     <= out_d;
    end
  end

  assign post_frame_vsync = vs_dly_q[3];
  assign post_frame_hsync = hs_dly_q[3];
  assign post_frame_de    = de_dly_q[3];
  assign post_img_data    = out_q;

endmodule

// File: tb/tb_ycbcr_sobel_edge.sv
// Bench for ycbcr_sobel_edge: frame-level scenario table plus a per-cycle frame-array reference model.
module tb_ycbcr_sobel_edge;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       vs, hs, de;
  logic [7:0] y, thr;
  logic       post_vs, post_hs, post_de;
  logic [7:0] post_data;

  always #5 clk = ~clk;

  ycbcr_sobel_edge #(.IMG_WIDTH(W), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst),
    .pre_frame_vsync(vs), .pre_frame_hsync(hs), .pre_frame_de(de),
    .img_y(y), .threshold(thr),
    .post_frame_vsync(post_vs), .post_frame_hsync(post_hs), .post_frame_de(post_de),
    .post_img_data(post_data)
  );

  typedef struct { logic de; logic vs; logic hs; logic [7:0] data; } exp_t;
  typedef struct { int pat; logic [7:0] thr; int lines; int exp_nz; logic [7:0] exp_val; } vec_t;

  exp_t pipe [4];
  int   pass_cnt = 0;
  int   total = 0;
  int   nz_cnt, match_cnt;
  logic [7:0] cur_val;
  int   img [16][W];
  int   rnd_img [16][W];
  int   mrow, mcol;
  logic m_de_prev, m_vs_prev;

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act == expv) pass_cnt++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
  endtask

  function automatic int pix(input int pat, input int r, input int c);
    case (pat)
      0: return 128;
      1: return (c < 4) ? 0 : 255;
      2: return (c < 4) ? 0 : 5;
      3: return (r < 3) ? 0 : 255;
      default: return rnd_img[r][c];
    endcase
  endfunction

  function automatic logic [7:0] sobel_ref(input int r, input int c, input int t);
    int gx, gy, mag;
    gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c]) - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
    gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c]) - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
    mag = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
`ifdef SOBEL_MAG_OUT_EN
    return (mag > 255) ? 8'hFF : 8'(mag);
`else
    return (mag > t) ? 8'hFF : 8'h00;
`endif
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) pipe[i] = '{1'b0, 1'b0, 1'b0, 8'h00};
    mrow = 0; mcol = 0; m_de_prev = 1'b0; m_vs_prev = 1'b0;
  endfunction

  task automatic step(input logic v, input logic h, input logic d, input logic [7:0] yy);
    exp_t e;
    @(negedge clk);
    check("ctrl", {post_vs, post_hs, post_de}, {pipe[3].vs, pipe[3].hs, pipe[3].de});
    check("data", post_data, pipe[3].data);
    if (post_de && post_data != 8'h00) begin
      nz_cnt++;
      if (post_data == cur_val) match_cnt++;
    end
    pipe[3] = pipe[2]; pipe[2] = pipe[1]; pipe[1] = pipe[0];
    vs = v; hs = h; de = d; y = yy;
    e = '{d, v, h, 8'h00};
    if (d) begin
      if (mrow < 16 && mcol < W) img[mrow][mcol] = yy;
      if (mrow >= 2 && mrow < 16 && mcol >= 2 && mcol < W) e.data = sobel_ref(mrow, mcol, thr);
      mcol++;
    end
    if (!d && m_de_prev) begin mrow++; mcol = 0; end
    if (v && !m_vs_prev) mrow = 0;
    m_de_prev = d; m_vs_prev = v;
    pipe[0] = e;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; vs = 1'b0; hs = 1'b0; de = 1'b0; y = 8'h00;
    #1;
    check("rst_async", {post_vs, post_hs, post_de, post_data}, 0);
    @(negedge clk);
    @(negedge clk);
    check("rst_hold", {post_vs, post_hs, post_de, post_data}, 0);
    rst = 1'b0;
    model_clear();
  endtask

  // Returns early (after a 2-cycle reset) when abort_row is reached mid-line.
  task automatic frame(input int pat, input int lines, input int abort_row);
    nz_cnt = 0; match_cnt = 0;
    repeat (2) step(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int r = 0; r < lines; r++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      for (int c = 0; c < W; c++) begin
        if (r == abort_row && c == W/2) begin
          do_reset();
          return;
        end
        step(1'b0, 1'b0, 1'b1, 8'(pix(pat, r, c)));
      end
      repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
    end
    repeat (6) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  vec_t tbl [5];

  initial begin
    tbl[0] = '{0, 8'h10, 6, 0, 8'hFF};
    tbl[1] = '{1, 8'h10, 6, 8, 8'hFF};
`ifdef SOBEL_MAG_OUT_EN
    tbl[2] = '{2, 8'd20, 6, 8, 8'h14};
    tbl[3] = '{2, 8'd19, 6, 8, 8'h14};
`else
    tbl[2] = '{2, 8'd20, 6, 0, 8'hFF};
    tbl[3] = '{2, 8'd19, 6, 8, 8'hFF};
`endif
    tbl[4] = '{3, 8'h10, 6, 12, 8'hFF};

    rst = 1'b1; vs = 1'b0; hs = 1'b0; de = 1'b0; y = 8'h00; thr = 8'h10;
    model_clear();
    repeat (3) @(negedge clk);
    check("reset_state", {post_vs, post_hs, post_de, post_data}, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      thr = tbl[i].thr;
      cur_val = tbl[i].exp_val;
      frame(tbl[i].pat, tbl[i].lines, -1);
      check($sformatf("nz_count[%0d]", i), nz_cnt, tbl[i].exp_nz);
      check($sformatf("edge_val[%0d]", i), match_cnt, tbl[i].exp_nz);
    end

    for (int f = 0; f < 12; f++) begin
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < W; c++)
          rnd_img[r][c] = (f < 4) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 1)) * 255;
      thr = 8'($urandom_range(0, 255));
      cur_val = 8'hFF;
      frame(4, 3 + int'($urandom_range(0, 5)), -1);
    end

    // Reset in row 3 of a vertical-step frame, then a horizontal-edge frame over stale buffers.
    thr = 8'h10;
    frame(1, 6, 3);
    cur_val = 8'hFF;
    frame(3, 6, -1);
    check("post_reset_nz", nz_cnt, 12);
    check("post_reset_val", match_cnt, 12);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
